// File: rtl/scan_rx_tag_chip.sv
// Receive side of the tag-chip scan interface: resynchronises the front-panel scan pins,
// deserialises the two-phase shifted hop code and qualifies each load by length and sequence.
module scan_rx_tag_chip #(
    parameter int TX_BITS_WIDTH = 128,
    parameter int BIT_CNT_WIDTH = 8,
    parameter int NTX_BITS      = 78,
    parameter int HOP_CNT_WIDTH = 7,
    parameter int TO_WIDTH      = 16,
    parameter int TIMEOUT       = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     scan_id,
    input  logic                     scan_phi,
    input  logic                     scan_phi_bar,
    input  logic                     scan_data_in,
    input  logic                     scan_load_chip,
    input  logic                     clr_err,
    output logic [TX_BITS_WIDTH-1:0] data_out,
    output logic                     data_valid,
    output logic                     chain_id,
    output logic [BIT_CNT_WIDTH-1:0] nbits_cnt,
    output logic [HOP_CNT_WIDTH-1:0] nloads,
    output logic                     len_err,
    output logic                     seq_err,
    output logic                     ovl_err,
    output logic                     err_sticky
);

    localparam int ID   = 4;
    localparam int PHI  = 3;
    localparam int PHIB = 2;
    localparam int DATA = 1;
    localparam int LOAD = 0;

    localparam logic [BIT_CNT_WIDTH-1:0] NBITS_FULL = BIT_CNT_WIDTH'(NTX_BITS);
    localparam logic [BIT_CNT_WIDTH-1:0] NBITS_SAT  = '1;
    localparam logic [TO_WIDTH-1:0]      TO_LIMIT   = TO_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        GAP   = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [4:0]               pins;
    logic [4:0]               meta;
    logic [4:0]               sync;
    logic [4:0]               dly;
    logic [TX_BITS_WIDTH-1:0] sreg;
    logic                     master;
    logic [TO_WIDTH-1:0]      to_cnt;
    logic                     sreg_unused;

    logic phi_rise, phi_fall, phib_rise, phib_fall, load_rise, any_edge, ovl_evt;
    logic do_capture, do_shift, do_accept, do_len, do_seq, do_ovl, frame_clr;

    assign pins = {scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
            dly  <= '0;
        end else begin
            meta <= pins;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign phi_rise  = sync[PHI]  & ~dly[PHI];
    assign phi_fall  = ~sync[PHI] &  dly[PHI];
    assign phib_rise = sync[PHIB] & ~dly[PHIB];
    assign phib_fall = ~sync[PHIB] & dly[PHIB];
    assign load_rise = sync[LOAD] & ~dly[LOAD];
    assign any_edge  = |(sync ^ dly);
    // Overlap is reported once when it begins, not on every cycle it persists
    assign ovl_evt   = sync[PHI] & sync[PHIB] & ~(dly[PHI] & dly[PHIB]);

    always_comb begin
        state_next = state;
        do_capture = 1'b0;
        do_shift   = 1'b0;
        do_accept  = 1'b0;
        do_len     = 1'b0;
        do_seq     = 1'b0;
        do_ovl     = 1'b0;
        frame_clr  = 1'b0;
        if (ovl_evt) begin
            do_ovl     = 1'b1;
            state_next = IDLE;
        end else if (load_rise) begin
            frame_clr  = 1'b1;
            state_next = IDLE;
            if (state == IDLE) begin
                if (nbits_cnt == NBITS_FULL) do_accept = 1'b1;
                else                         do_len    = 1'b1;
            end else begin
                do_seq = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (phi_rise) begin
                        state_next = CAPT;
                        do_capture = 1'b1;
                    end else if (phib_rise) begin
                        do_seq = 1'b1;
                    end
                end
                CAPT: begin
                    if (phi_fall) state_next = GAP;
                end
                GAP: begin
                    if (phib_rise) begin
                        state_next = SHIFT;
                        do_shift   = 1'b1;
                    end else if (phi_rise) begin
                        do_seq     = 1'b1;
                        state_next = IDLE;
                    end
                end
                SHIFT: begin
                    if (phib_fall) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
            // A stalled partial frame is silently abandoned
            if ((to_cnt == TO_LIMIT) && (nbits_cnt != '0)) begin
                frame_clr  = 1'b1;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            master     <= 1'b0;
            sreg       <= '0;
            to_cnt     <= '0;
            nbits_cnt  <= '0;
            data_out   <= '0;
            chain_id   <= 1'b0;
            nloads     <= '0;
            data_valid <= 1'b0;
            len_err    <= 1'b0;
            seq_err    <= 1'b0;
            ovl_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_next;
            data_valid <= do_accept;
            len_err    <= do_len;
            seq_err    <= do_seq;
            ovl_err    <= do_ovl;
            if (do_capture) master <= sync[DATA];
            if (do_shift)   sreg   <= {sreg[TX_BITS_WIDTH-2:0], master};
            if (any_edge)              to_cnt <= '0;
            else if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 1'b1;
            if (frame_clr) begin
                nbits_cnt <= '0;
            end else if (do_shift && (nbits_cnt != NBITS_SAT)) begin
                nbits_cnt <= nbits_cnt + 1'b1;
            end
            if (do_accept) begin
                data_out <= TX_BITS_WIDTH'(sreg[NTX_BITS-1:0]);
                chain_id <= sync[ID];
                nloads   <= nloads + 1'b1;
            end
            if (do_len || do_seq || do_ovl) err_sticky <= 1'b1;
            else if (clr_err)               err_sticky <= 1'b0;
        end
    end

    assign sreg_unused = sreg[TX_BITS_WIDTH-1];

endmodule

// File: tb/tb_scan_rx_tag_chip.sv
// Randomised bench for scan_rx_tag_chip: a frame-level model (bit queue + counters) predicts
// the settled outputs, which one process compares every cycle; pulse counts are checked per operation.
module tb_scan_rx_tag_chip;

    localparam int W   = 128;
    localparam int NTX = 78;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, clr_err;
    logic [W-1:0]   data_out;
    logic           data_valid, chain_id, len_err, seq_err, ovl_err, err_sticky;
    logic [7:0]     nbits_cnt;
    logic [6:0]     nloads;

    always #5 clk = ~clk;

    scan_rx_tag_chip dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .scan_id        (scan_id),
        .scan_phi       (scan_phi),
        .scan_phi_bar   (scan_phi_bar),
        .scan_data_in   (scan_data_in),
        .scan_load_chip (scan_load_chip),
        .clr_err        (clr_err),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .chain_id       (chain_id),
        .nbits_cnt      (nbits_cnt),
        .nloads         (nloads),
        .len_err        (len_err),
        .seq_err        (seq_err),
        .ovl_err        (ovl_err),
        .err_sticky     (err_sticky)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Frame-level model: bits shifted since the last clear, plus accepted-frame state
    bit           frame_q[$];
    logic [W-1:0] m_data_out = '0;
    logic         m_chain    = 1'b0;
    logic         m_sticky   = 1'b0;
    int           m_accepted = 0;
    bit           settled    = 1'b0;

    int dv_cnt = 0, len_cnt = 0, seq_cnt = 0, ovl_cnt = 0;
    int s_dv, s_len, s_seq, s_ovl;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_nbits();
        return (frame_q.size() > 255) ? 255 : frame_q.size();
    endfunction

    always @(posedge clk) begin
        #3;
        if (data_valid === 1'b1) dv_cnt++;
        if (len_err === 1'b1)    len_cnt++;
        if (seq_err === 1'b1)    seq_cnt++;
        if (ovl_err === 1'b1)    ovl_cnt++;
    end

    always @(posedge clk) begin
        #3;
        if (settled) begin
            check_output("data_out",   data_out,   m_data_out);
            check_output("nbits_cnt",  W'(nbits_cnt), W'(m_nbits()));
            check_output("nloads",     W'(nloads), W'(m_accepted % 128));
            check_output("chain_id",   W'(chain_id), W'(m_chain));
            check_output("err_sticky", W'(err_sticky), W'(m_sticky));
        end
    end

    task automatic begin_op();
        settled = 1'b0;
        s_dv  = dv_cnt;
        s_len = len_cnt;
        s_seq = seq_cnt;
        s_ovl = ovl_cnt;
    endtask

    task automatic end_op(input int e_dv, input int e_len, input int e_seq, input int e_ovl);
        repeat (6) @(negedge clk);
        check_output("data_valid pulses", W'(dv_cnt - s_dv),  W'(e_dv));
        check_output("len_err pulses",    W'(len_cnt - s_len), W'(e_len));
        check_output("seq_err pulses",    W'(seq_cnt - s_seq), W'(e_seq));
        check_output("ovl_err pulses",    W'(ovl_cnt - s_ovl), W'(e_ovl));
        settled = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic shift_bit(input bit b);
        @(negedge clk);
        scan_data_in = b;
        scan_phi     = 1'b1;
        @(negedge clk);
        scan_phi     = 1'b0;
        @(negedge clk);
        scan_phi_bar = 1'b1;
        @(negedge clk);
        scan_phi_bar = 1'b0;
        frame_q.push_back(b);
    endtask

    task automatic ovl_glitch();
        @(negedge clk);
        scan_phi     = 1'b1;
        @(negedge clk);
        scan_phi_bar = 1'b1;
        @(negedge clk);
        @(negedge clk);
        scan_phi     = 1'b0;
        @(negedge clk);
        scan_phi_bar = 1'b0;
        m_sticky = 1'b1;
    endtask

    // Load held high for several cycles: only its rising edge may act
    task automatic pulse_load();
        @(negedge clk);
        scan_load_chip = 1'b1;
        repeat (3) @(negedge clk);
        scan_load_chip = 1'b0;
    endtask

    task automatic model_load(input bit id, output int e_dv, output int e_len);
        e_dv  = 0;
        e_len = 0;
        if (frame_q.size() == NTX) begin
            m_data_out = '0;
            for (int i = 0; i < NTX; i++) m_data_out[i] = frame_q[frame_q.size() - 1 - i];
            m_chain = id;
            m_accepted++;
            e_dv = 1;
        end else begin
            e_len    = 1;
            m_sticky = 1'b1;
        end
        frame_q.delete();
    endtask

    task automatic apply_stimulus(input int n, input int ovl_pos, input bit id, input logic [W-1:0] bits);
        int e_dv, e_len, e_ovl;
        e_ovl = 0;
        begin_op();
        @(negedge clk);
        scan_id = id;
        for (int i = 0; i < n; i++) begin
            if (i == ovl_pos) begin
                ovl_glitch();
                e_ovl = 1;
            end
            shift_bit(bits[n - 1 - i]);
        end
        pulse_load();
        model_load(id, e_dv, e_len);
        end_op(e_dv, e_len, 0, e_ovl);
    endtask

    task automatic op_seq_load(input int k, input logic [W-1:0] bits);
        begin_op();
        for (int i = 0; i < k; i++) shift_bit(bits[i]);
        @(negedge clk);
        scan_phi = 1'b1;
        @(negedge clk);
        scan_load_chip = 1'b1;
        @(negedge clk);
        scan_phi = 1'b0;
        repeat (2) @(negedge clk);
        scan_load_chip = 1'b0;
        frame_q.delete();
        m_sticky = 1'b1;
        end_op(0, 0, 1, 0);
    endtask

    task automatic op_gap_seq(input int k, input logic [W-1:0] bits);
        begin_op();
        for (int i = 0; i < k; i++) shift_bit(bits[i]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            scan_phi = 1'b1;
            @(negedge clk);
            scan_phi = 1'b0;
        end
        m_sticky = 1'b1;
        end_op(0, 0, 1, 0);
    endtask

    task automatic op_idle_phibar();
        begin_op();
        @(negedge clk);
        scan_phi_bar = 1'b1;
        @(negedge clk);
        scan_phi_bar = 1'b0;
        m_sticky = 1'b1;
        end_op(0, 0, 1, 0);
    endtask

    task automatic op_clear();
        begin_op();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_sticky = 1'b0;
        end_op(0, 0, 0, 0);
    endtask

    logic [W-1:0] pat;
    logic [W-1:0] rnd;
    bit           wrap_checked = 1'b0;

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        scan_id = 1'b0; scan_phi = 1'b0; scan_phi_bar = 1'b0;
        scan_data_in = 1'b0; scan_load_chip = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset data_out",   data_out, '0);
        check_output("reset nbits_cnt",  W'(nbits_cnt), '0);
        check_output("reset nloads",     W'(nloads), '0);
        check_output("reset err_sticky", W'(err_sticky), '0);
        check_output("reset data_valid", W'(data_valid), '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        settled = 1'b1;

        // 78-bit frame of the repeating A5C3 pattern, shifted MSB first
        pat = {48'h0, {5{16'hA5C3}}};
        pat[W-1:NTX] = '0;
        apply_stimulus(NTX, -1, 1'b1, pat);
        check_output("pattern low word",  W'(data_out[15:0]),  W'(16'hA5C3));
        check_output("pattern top bits",  W'(data_out[77:64]), W'(14'h25C3));
        check_output("pattern upper zero", W'(data_out[W-1:NTX]), '0);
        check_output("pattern nloads",    W'(nloads), W'(7'd1));
        check_output("pattern chain_id",  W'(chain_id), W'(1'b1));

        // One bit short: rejected, previous frame kept
        rnd = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(NTX - 1, -1, 1'b0, rnd);
        check_output("short frame held", W'(data_out[15:0]), W'(16'hA5C3));
        check_output("short frame nbits", W'(nbits_cnt), '0);
        check_output("short frame sticky", W'(err_sticky), W'(1'b1));
        op_clear();
        check_output("cleared sticky", W'(err_sticky), '0);

        // Error and clear landing on the same edge: the error wins
        begin_op();
        for (int i = 0; i < 5; i++) shift_bit(rnd[i]);
        @(negedge clk);
        scan_load_chip = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        scan_load_chip = 1'b0;
        frame_q.delete();
        m_sticky = 1'b1;
        end_op(0, 1, 0, 0);
        check_output("set beats clear", W'(err_sticky), W'(1'b1));

        // Overlap mid-frame drops one capture; the frame still completes at 78 shifts
        rnd = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(NTX, 40, 1'b0, rnd);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(NTX, -1, 1'b1, rnd);

        op_seq_load(20, rnd);
        check_output("seq load nbits", W'(nbits_cnt), '0);

        // Stalled partial frame is dropped after the timeout, not before
        begin_op();
        for (int i = 0; i < 10; i++) shift_bit(rnd[i]);
        repeat (4000) @(negedge clk);
        check_output("before timeout nbits", W'(nbits_cnt), W'(8'd10));
        repeat (110) @(negedge clk);
        check_output("after timeout nbits", W'(nbits_cnt), '0);
        frame_q.delete();
        end_op(0, 0, 0, 0);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(NTX, -1, 1'b0, rnd);

        // Asynchronous reset in the middle of a frame, between clock edges
        begin_op();
        for (int i = 0; i < 30; i++) shift_bit(rnd[i]);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        scan_phi = 1'b0; scan_phi_bar = 1'b0; scan_load_chip = 1'b0; scan_id = 1'b0;
        #1;
        check_output("async reset data_out", data_out, '0);
        check_output("async reset nloads",   W'(nloads), '0);
        check_output("async reset nbits",    W'(nbits_cnt), '0);
        check_output("async reset chain_id", W'(chain_id), '0);
        check_output("async reset sticky",   W'(err_sticky), '0);
        frame_q.delete();
        m_data_out = '0;
        m_chain    = 1'b0;
        m_sticky   = 1'b0;
        m_accepted = 0;
        @(negedge clk);
        reset_n = 1'b1;
        end_op(0, 0, 0, 0);

        // Random mix of good and faulty traffic until the load counter has wrapped
        for (int iter = 0; iter < 400 && m_accepted < 130; iter++) begin
            int r;
            rnd = {$urandom, $urandom, $urandom, $urandom};
            r = $urandom_range(0, 11);
            if (r <= 6)       apply_stimulus(NTX, -1, 1'($urandom_range(0, 1)), rnd);
            else if (r == 7)  apply_stimulus(($urandom_range(0, 1) != 0) ? $urandom_range(1, NTX - 1) : $urandom_range(NTX + 1, NTX + 4),
                                             -1, 1'($urandom_range(0, 1)), rnd);
            else if (r == 8)  apply_stimulus(NTX, $urandom_range(1, NTX - 1), 1'($urandom_range(0, 1)), rnd);
            else if (r == 9)  op_seq_load($urandom_range(0, 30), rnd);
            else if (r == 10) op_gap_seq($urandom_range(0, 10), rnd);
            else if ($urandom_range(0, 1) != 0) op_idle_phibar();
            else              op_clear();
            if (m_accepted == 128 && !wrap_checked) begin
                wrap_checked = 1'b1;
                check_output("nloads wrap", W'(nloads), '0);
            end
        end
        check_output("reached wrap", W'(m_accepted >= 130), W'(1'b1));

        settled = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
